seven_seg_scanner: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display.
- Replaces the fixed 4-panel scan with:
  - an internal refresh prescaler
  - an anti-ghosting blank interval between digits
  - hex plus blank decoding
  - per-digit blink masking for clock-adjust mode
- Sits between the stopwatch digit counters and the board's seg/an pins.

---
 rtl/seven_seg_pkg.sv | 33 +++
 rtl/seven_seg_decode.sv | 17 +
 rtl/seven_seg_scanner.sv | 156 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [4:0] BLANK_CODE = 5'd16;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Entry n holds the pattern for hex value n.
    localparam logic [15:0][6:0] SEG_HEX = {SEG_F, SEG_E, SEG_D, SEG_C,
                                            SEG_B, SEG_A, SEG_9, SEG_8,
                                            SEG_7, SEG_6, SEG_5, SEG_4,
                                            SEG_3, SEG_2, SEG_1, SEG_0};

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

endpackage

// File: rtl/seven_seg_decode.sv
// 5-bit digit code to active-low segment pattern; codes 16-31 are blank.
// Purely combinational, no backpressure.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (code_i < BLANK_CODE) begin
            seg_o = SEG_HEX[code_i[3:0]];
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode driver with blank interval and blink masking.
// Outputs registered (one cycle from digits to seg); free-running, no backpressure.
// Optional leading-zero suppression under SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*NUM_DIGITS-1:0] digits,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic [4:0]              code_mux;
    logic                    blink_mux;
    logic                    sup_mux;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   lz_sup;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CW'(1);
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_d = '0;
                            phase_d     = ~phase_q;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                        end
                    end
                end
            end
        endcase
        // Holding at zero makes every enable start with a visible half-period.
        if (!blink_en) begin
            frame_cnt_d = '0;
            phase_d     = 1'b0;
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic lead;
    always_comb begin
        lz_sup = '0;
        lead   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (digits[5*i +: 5] == 5'd0) begin
                lz_sup[i] = lead;
            end else if (digits[5*i +: 5] < BLANK_CODE) begin
                lead = 1'b0;
            end
        end
    end
`else
    assign lz_sup = '0;
`endif

    // Outputs are registered, so select using the state being entered.
    always_comb begin
        code_mux  = BLANK_CODE;
        blink_mux = 1'b0;
        sup_mux   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                code_mux  = digits[5*i +: 5];
                blink_mux = blink_mask[i];
                sup_mux   = lz_sup[i];
            end
        end
    end

    seven_seg_decode u_decode (
        .code_i (code_mux),
        .seg_o  (dec_seg)
    );

    always_comb begin
        an_d          = '1;
        seg_d         = SEG_BLANK;
        frame_start_d = 1'b0;
        if (state_d == ST_SHOW) begin
            an_d          = ~(NUM_DIGITS'(1) << idx_d);
            seg_d         = ((blink_en && phase_q && blink_mux) || sup_mux) ? SEG_BLANK : dec_seg;
            frame_start_d = (state_q == ST_BLANK) && (idx_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            idx_q         <= '0;
            cnt_q         <= '0;
            frame_cnt_q   <= '0;
            phase_q       <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            phase_q       <= phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with a small scan-position reference model.
module tb_seven_seg_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int DP = RD + BC;
    localparam int FP = ND * DP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [19:0]   digits;
    logic          blink_en;
    logic [3:0]    blink_mask;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          frame_start;

    int n_vec = 0;
    int n_bad = 0;
    int k     = 0;
    int fe    = 0;
    int fs_seen = 0;
    logic [11:0] exp_q[$];

    seven_seg_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .blink_en    (blink_en),
        .blink_mask  (blink_mask),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_dec(input logic [4:0] c);
        case (c)
            5'd0:  return 7'b1000000;
            5'd1:  return 7'b1111001;
            5'd2:  return 7'b0100100;
            5'd3:  return 7'b0110000;
            5'd4:  return 7'b0011001;
            5'd5:  return 7'b0010010;
            5'd6:  return 7'b0000010;
            5'd7:  return 7'b1111000;
            5'd8:  return 7'b0000000;
            5'd9:  return 7'b0010000;
            5'd10: return 7'b0001000;
            5'd11: return 7'b0000011;
            5'd12: return 7'b1000110;
            5'd13: return 7'b0100001;
            5'd14: return 7'b0000110;
            5'd15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

`ifdef SEVEN_SEG_LZ_BLANK_EN
    function automatic logic lz_ref(input logic [19:0] dg, input int d);
        if (d == 0 || dg[5*d +: 5] != 5'd0) return 1'b0;
        for (int j = d + 1; j < ND; j++) begin
            if (dg[5*j +: 5] != 5'd0 && dg[5*j +: 5] < 5'd16) return 1'b0;
        end
        return 1'b1;
    endfunction
`endif

    // Predict the outputs after the next edge, queue them, then compare.
    task automatic step();
        int s, d, w;
        logic ph, sup;
        logic [3:0] one;
        logic [3:0] ea;
        logic [6:0] es;
        logic ef;
        logic [11:0] got, want;
        k++;
        s   = k % FP;
        d   = s / DP;
        w   = s % DP;
        ph  = ((fe / BF) % 2) == 1;
        one = 4'b0001;
        ea  = 4'hF;
        es  = 7'h7F;
        ef  = 1'b0;
        if (w >= BC) begin
`ifdef SEVEN_SEG_LZ_BLANK_EN
            sup = lz_ref(digits, d);
`else
            sup = 1'b0;
`endif
            ea = ~(one << d);
            es = ((blink_en && ph && blink_mask[d]) || sup) ? 7'h7F : ref_dec(digits[5*d +: 5]);
            ef = (d == 0) && (w == BC);
        end
        if (!blink_en) fe = 0;
        else if (s == 0) fe++;
        exp_q.push_back({ea, es, ef});
        @(posedge clk);
        #1;
        got  = {an, seg, frame_start};
        want = exp_q.pop_front();
        if (got[0]) fs_seen++;
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL scan k=%0d: an/seg/fs got %b/%b/%b want %b/%b/%b",
                     k, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k  = 0;
        fe = 0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        digits     = {5'd9, 5'd5, 5'd3, 5'd1};
        blink_en   = 1'b0;
        blink_mask = 4'b0000;
        #12;
        n_vec++;
        if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: an/seg/fs got %b/%b/%b want 1111/1111111/0", an, seg, frame_start);
        end
        do_reset();
    endtask

    task automatic test_scan();
        digits  = {5'd9, 5'd5, 5'd3, 5'd1};
        do_reset();
        fs_seen = 0;
        repeat (2 * FP) step();
        n_vec++;
        if (fs_seen != 2) begin
            n_bad++;
            $display("FAIL frame_start_count: got %0d want 2", fs_seen);
        end
    endtask

    task automatic test_decode();
        digits = {5'd0, 5'd0, 5'd20, 5'd10};
        repeat (FP) step();
        for (int c = 0; c < 32; c += 4) begin
            digits = {5'(c + 3), 5'(c + 2), 5'(c + 1), 5'(c)};
            repeat (FP) step();
        end
    endtask

    task automatic test_live_update();
        repeat (60) begin
            digits = 20'($urandom);
            step();
        end
    endtask

    task automatic test_blink();
        digits     = {5'd8, 5'd8, 5'd8, 5'd8};
        blink_mask = 4'b0011;
        blink_en   = 1'b1;
        do_reset();
        repeat (5 * FP) step();
    endtask

    task automatic test_blink_drop();
        digits     = {5'd4, 5'd3, 5'd2, 5'd1};
        blink_mask = 4'b0011;
        blink_en   = 1'b1;
        do_reset();
        repeat (2 * FP + 8) step();
        blink_en = 1'b0;
        repeat (FP) step();
        blink_en = 1'b1;
        repeat (3 * FP) step();
        blink_en = 1'b0;
    endtask

    task automatic test_mask_zero();
        digits     = {5'd7, 5'd6, 5'd5, 5'd4};
        blink_mask = 4'b0000;
        blink_en   = 1'b1;
        do_reset();
        repeat (4 * FP) step();
        blink_en = 1'b0;
    endtask

    task automatic test_async_reset();
        digits = {5'd12, 5'd11, 5'd10, 5'd9};
        do_reset();
        repeat (15) step();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({an, seg, frame_start} !== {4'hF, 7'h7F, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: an/seg/fs got %b/%b/%b want 1111/1111111/0", an, seg, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k  = 0;
        fe = 0;
        repeat (30) step();
    endtask

    task automatic test_lz();
        do_reset();
        digits = {5'd0, 5'd0, 5'd0, 5'd0};
        repeat (FP) step();
        digits = {5'd0, 5'd1, 5'd0, 5'd0};
        repeat (FP) step();
        digits = {5'd16, 5'd0, 5'd0, 5'd5};
        repeat (FP) step();
        digits = {5'd0, 5'd0, 5'd7, 5'd0};
        repeat (FP) step();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_live_update();
        test_blink();
        test_blink_drop();
        test_mask_zero();
        test_async_reset();
        test_lz();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
